pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the 6-stage pipeline. It replaces the fixed-field, always-advance stage registers (IF/ID, ID/RR, RR/EX, ...).
- Carries a generic payload plus a separately treated control-bit vector. Adds valid/ready flow control, an optional 2-entry skid buffer, flush-to-bubble and a saturating stall counter.
- One instance sits between each pair of adjacent pipeline stages.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_stage_reg.sv | 165 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control-bit
// layout, skid-buffer state encoding and per-stage payload widths.
package pipe_pkg;

  // Control-bit vector layout. A bubble carries all-zero control bits.
  localparam int CTRL_W        = 7;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_REGDST   = 1;
  localparam int CTRL_ALUOP    = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_BRANCH   = 6;

  // Skid-buffer occupancy: EMPTY (nothing held), FULL (main only), SKID (both).
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL,
    S_SKID  = ST_SKID
  } skid_st_e;

  // Default payload width for each stage boundary.
  localparam int DATA_W_IF_ID  = 64;
  localparam int DATA_W_ID_RR  = 64;
  localparam int DATA_W_RR_EX  = 64;
  localparam int DATA_W_EX_MEM = 64;
  localparam int DATA_W_MEM_WB = 64;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = pipe_pkg::CTRL_W,
  parameter int PC_W    = 32,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);
  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_vld;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PC_W-1:0]   main_pc;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_vld && out_ready;
  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;  // stored ctrl is zero whenever main is invalid
  assign out_pc    = main_pc;

  generate
    if (SKID_EN != 0) begin : g_skid
      skid_st_e          st, st_nxt;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [PC_W-1:0]   skid_pc;
      logic              main_ld_in, main_ld_skid, main_clr, skid_ld;

      // in_ready is decoded straight from the state register, never from out_ready.
      assign in_ready = (st != S_SKID);
      assign main_vld = (st != S_EMPTY);

      // Next-state and register-bank load selects.
      always_comb begin
        st_nxt       = st;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        main_clr     = 1'b0;
        skid_ld      = 1'b0;
        case (st)
          S_EMPTY: if (in_xfer) begin
            st_nxt     = S_FULL;
            main_ld_in = 1'b1;
          end
          S_FULL: begin
            if (in_xfer && out_xfer) begin
              main_ld_in = 1'b1;
            end else if (in_xfer) begin
              st_nxt  = S_SKID;
              skid_ld = 1'b1;
            end else if (out_xfer) begin
              st_nxt   = S_EMPTY;
              main_clr = 1'b1;
            end
          end
          S_SKID: if (out_xfer) begin
            st_nxt       = S_FULL;
            main_ld_skid = 1'b1;
          end
          default: st_nxt = S_EMPTY;
        endcase
      end

      // Occupancy state; flush empties both entries.
      always_ff @(posedge clk) begin
        if (reset)      st <= S_EMPTY;
        else if (flush) st <= S_EMPTY;
        else            st <= st_nxt;
      end

      // Main entry: loads from input or promotes the skid entry (oldest first).
      always_ff @(posedge clk) begin
        if (reset) begin
          main_data <= '0;
          main_ctrl <= '0;
          main_pc   <= '0;
        end else if (flush) begin
          main_ctrl <= '0;
        end else if (main_ld_in) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
          main_pc   <= in_pc;
        end else if (main_ld_skid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
          main_pc   <= skid_pc;
        end else if (main_clr) begin
          main_ctrl <= '0;
        end
      end

      // Skid entry: captures the input that arrives while main is stalled.
      always_ff @(posedge clk) begin
        if (reset) begin
          skid_data <= '0;
          skid_ctrl <= '0;
          skid_pc   <= '0;
        end else if (flush) begin
          skid_ctrl <= '0;
        end else if (skid_ld) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
          skid_pc   <= in_pc;
        end else if (main_ld_skid) begin
          skid_ctrl <= '0;
        end
      end
    end else begin : g_single
      // Single register: accept whenever the held entry leaves or none is held.
      assign in_ready = out_ready || !main_vld;

      // Main entry: load on input, drop to bubble when drained.
      always_ff @(posedge clk) begin
        if (reset) begin
          main_vld  <= 1'b0;
          main_data <= '0;
          main_ctrl <= '0;
          main_pc   <= '0;
        end else if (flush) begin
          main_vld  <= 1'b0;
          main_ctrl <= '0;
        end else if (in_xfer) begin
          main_vld  <= 1'b1;
          main_data <= in_data;
          main_ctrl <= in_ctrl;
          main_pc   <= in_pc;
        end else if (out_xfer) begin
          main_vld  <= 1'b0;
          main_ctrl <= '0;
        end
      end
    end
  endgenerate

  // Saturating count of stalled cycles; a flush cycle is not counted.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!flush && main_vld && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (16-bit counter) and a single-register
// instance (4-bit counter) share stimulus; each is checked against a queue model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [6:0]  in_ctrl;
  logic [31:0] in_pc;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [63:0] a_out_data, b_out_data;
  logic [6:0]  a_out_ctrl, b_out_ctrl;
  logic [31:0] a_out_pc, b_out_pc;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID_EN(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .out_pc(a_out_pc), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.SKID_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .out_pc(b_out_pc), .stall_cnt(b_stall)
  );

  // Reference model: FIFO contents in arrival order, capacity 2 (skid) or 1.
  typedef struct { logic [31:0] pc; logic [63:0] data; logic [6:0] ctrl; } ent_t;
  ent_t qa[$];
  ent_t qb[$];
  int   ca = 0;
  int   cb = 0;
  bit   ir_a_obs, ir_b_obs;

  typedef struct {
    bit r, fl, iv, ordy;
    logic [31:0] pc;
    logic [6:0]  ctrl;
    bit eir, eov;
    logic [31:0] epc;
    logic [6:0]  ectrl;
    int est;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t v(bit r, bit fl, bit iv, bit ordy, logic [31:0] pc, logic [6:0] ctrl,
                             bit eir, bit eov, logic [31:0] epc, logic [6:0] ectrl, int est);
    vec_t t;
    t.r = r; t.fl = fl; t.iv = iv; t.ordy = ordy; t.pc = pc; t.ctrl = ctrl;
    t.eir = eir; t.eov = eov; t.epc = epc; t.ectrl = ectrl; t.est = est;
    return t;
  endfunction

  function automatic logic [63:0] dat(logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
  task automatic cyc(input bit r, input bit fl, input bit iv, input bit ordy,
                     input logic [31:0] pc, input logic [6:0] ctrl);
    bit   ira, irb;
    ent_t e;
    reset = r; flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_ctrl = ctrl; in_data = dat(pc);
    e.pc = pc; e.data = dat(pc); e.ctrl = ctrl;
    #1;
    ira = (qa.size() < 2);
    irb = ordy || (qb.size() == 0);
    ir_a_obs = a_in_ready;
    ir_b_obs = b_in_ready;
    chk("a_in_ready", a_in_ready, ira);
    chk("b_in_ready", b_in_ready, irb);
    if (r) begin
      qa.delete(); qb.delete(); ca = 0; cb = 0;
    end else if (fl) begin
      qa.delete(); qb.delete();
    end else begin
      if (qa.size() > 0 && !ordy && ca < 65535) ca++;
      if (qb.size() > 0 && !ordy && cb < 15) cb++;
      if (qa.size() > 0 && ordy) void'(qa.pop_front());
      if (qb.size() > 0 && ordy) void'(qb.pop_front());
      if (iv && ira) qa.push_back(e);
      if (iv && irb) qb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("a_out_valid", a_out_valid, qa.size() > 0);
    chk("a_out_ctrl", a_out_ctrl, qa.size() > 0 ? qa[0].ctrl : 7'd0);
    if (qa.size() > 0) begin
      chk("a_out_pc", a_out_pc, qa[0].pc);
      chk("a_out_data", a_out_data, qa[0].data);
    end
    chk("a_stall_cnt", a_stall, ca);
    chk("b_out_valid", b_out_valid, qb.size() > 0);
    chk("b_out_ctrl", b_out_ctrl, qb.size() > 0 ? qb[0].ctrl : 7'd0);
    if (qb.size() > 0) begin
      chk("b_out_pc", b_out_pc, qb[0].pc);
      chk("b_out_data", b_out_data, qb[0].data);
    end
    chk("b_stall_cnt", b_stall, cb);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              r fl iv ordy pc      ctrl   eir eov epc     ectrl  est
    tbl[0]  = v(1, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 0);
    tbl[1]  = v(1, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 0);
    tbl[2]  = v(0, 0, 1, 1, 32'h100, 7'h01, 1, 1, 32'h100, 7'h01, 0);
    tbl[3]  = v(0, 0, 1, 1, 32'h104, 7'h02, 1, 1, 32'h104, 7'h02, 0);
    tbl[4]  = v(0, 0, 1, 1, 32'h108, 7'h04, 1, 1, 32'h108, 7'h04, 0);
    tbl[5]  = v(0, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 0);
    tbl[6]  = v(0, 0, 1, 1, 32'h200, 7'h11, 1, 1, 32'h200, 7'h11, 0);
    tbl[7]  = v(0, 0, 1, 0, 32'h204, 7'h22, 1, 1, 32'h200, 7'h11, 1);
    tbl[8]  = v(0, 0, 1, 0, 32'h208, 7'h33, 0, 1, 32'h200, 7'h11, 2);
    tbl[9]  = v(0, 0, 0, 1, 32'h0,   7'h00, 0, 1, 32'h204, 7'h22, 2);
    tbl[10] = v(0, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 2);
    tbl[11] = v(0, 0, 1, 0, 32'h210, 7'h7F, 1, 1, 32'h210, 7'h7F, 2);
    tbl[12] = v(0, 0, 1, 0, 32'h214, 7'h7F, 1, 1, 32'h210, 7'h7F, 3);
    tbl[13] = v(0, 1, 1, 0, 32'h300, 7'h7F, 0, 0, 32'h0,   7'h00, 3);
    tbl[14] = v(0, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 3);
    tbl[15] = v(0, 1, 1, 1, 32'h304, 7'h7F, 1, 0, 32'h0,   7'h00, 3);
    tbl[16] = v(0, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 3);
    tbl[17] = v(0, 0, 1, 0, 32'h400, 7'h7F, 1, 1, 32'h400, 7'h7F, 3);
    tbl[18] = v(0, 0, 1, 0, 32'h404, 7'h7F, 1, 1, 32'h400, 7'h7F, 4);
    tbl[19] = v(1, 1, 1, 0, 32'h408, 7'h7F, 0, 0, 32'h0,   7'h00, 0);
    tbl[20] = v(0, 0, 0, 1, 32'h0,   7'h00, 1, 0, 32'h0,   7'h00, 0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_ctrl = '0; in_data = '0;
    @(posedge clk);
    #1;

    // Directed vectors against the skid instance.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].r, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].pc, tbl[i].ctrl);
      chk("tbl_in_ready", ir_a_obs, tbl[i].eir);
      chk("tbl_out_valid", a_out_valid, tbl[i].eov);
      chk("tbl_out_ctrl", a_out_ctrl, tbl[i].ectrl);
      if (tbl[i].eov || tbl[i].r) begin
        chk("tbl_out_pc", a_out_pc, tbl[i].epc);
        chk("tbl_out_data", a_out_data, tbl[i].eov ? dat(tbl[i].epc) : 64'h0);
      end
      chk("tbl_stall_cnt", a_stall, tbl[i].est);
    end

    // Counter saturation: 4-bit counter holds at 15, 16-bit one reaches 20.
    cyc(1, 0, 0, 1, 32'h0, 7'h00);
    cyc(0, 0, 1, 1, 32'h600, 7'h05);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 32'h0, 7'h00);
      if (i == 14) chk("sat_reach15", b_stall, 4'd15);
    end
    chk("sat_hold15", b_stall, 4'd15);
    chk("sat_wide20", a_stall, 16'd20);
    chk("sat_pc_held", b_out_pc, 32'h600);
    cyc(1, 0, 0, 0, 32'h0, 7'h00);
    chk("sat_reset_b", b_stall, 4'd0);
    chk("sat_reset_a", a_stall, 16'd0);

    // Single-register mode: same-cycle replace, then stall.
    cyc(0, 0, 1, 1, 32'h500, 7'h0A);
    chk("ns_load_pc", b_out_pc, 32'h500);
    cyc(0, 0, 1, 1, 32'h504, 7'h0B);
    chk("ns_comb_ready", ir_b_obs, 1'b1);
    chk("ns_replace_valid", b_out_valid, 1'b1);
    chk("ns_replace_pc", b_out_pc, 32'h504);
    cyc(0, 0, 1, 0, 32'h508, 7'h0C);
    chk("ns_stall_ready", ir_b_obs, 1'b0);
    chk("ns_hold_pc", b_out_pc, 32'h504);
    chk("ns_hold_ctrl", b_out_ctrl, 7'h0B);
    cyc(0, 0, 0, 1, 32'h0, 7'h00);
    cyc(0, 0, 0, 1, 32'h0, 7'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom, 7'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
